// File: rtl/hp_judge.sv
// hp_judge: two-player hit-point match referee with lockout and next-question pacing
module hp_judge #(
    parameter int HP_INIT  = 3,
    parameter int LOCK_CYC = 50_000_000,
    parameter int NEXT_CYC = 25_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       OK1,
    input  logic       OK2,
    input  logic       MISS1,
    input  logic       MISS2,
    output logic [1:0] JUDG,
    output logic [1:0] HP1,
    output logic [1:0] HP2,
    output logic       WRONG1,
    output logic       WRONG2,
    output logic       NEXT,
    output logic [1:0] STATE
);
    localparam int LW = $clog2(LOCK_CYC + 1);
    localparam int NW = NEXT_CYC > 1 ? $clog2(NEXT_CYC) : 1;

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WAIT = 2'b10, OVER = 2'b11} state_t;

    state_t        state_q, state_d;
    logic [1:0]    hp1_q, hp1_d, hp2_q, hp2_d, judg_q, judg_d;
    logic [LW-1:0] lock1_q, lock1_d, lock2_q, lock2_d;
    logic [NW-1:0] wait_q, wait_d;
    logic          next_q, next_d;
    logic          ok1_v, ok2_v, miss1_v, miss2_v;
    logic [1:0]    dmg1, dmg2, hp1_n, hp2_n;

    // Qualify answers (locked players ignored, OK beats MISS) and apply saturating damage
    always_comb begin
        ok1_v   = state_q == PLAY && OK1 && lock1_q == '0;
        ok2_v   = state_q == PLAY && OK2 && lock2_q == '0;
        miss1_v = state_q == PLAY && MISS1 && !OK1 && lock1_q == '0;
        miss2_v = state_q == PLAY && MISS2 && !OK2 && lock2_q == '0;
        dmg1    = {1'b0, ok2_v} + {1'b0, miss1_v};
        dmg2    = {1'b0, ok1_v} + {1'b0, miss2_v};
        hp1_n   = hp1_q > dmg1 ? hp1_q - dmg1 : 2'd0;
        hp2_n   = hp2_q > dmg2 ? hp2_q - dmg2 : 2'd0;
    end

    // Next-state logic; lockout and wait counters fall to zero whenever not in use
    always_comb begin
        state_d = state_q;
        hp1_d   = hp1_q;
        hp2_d   = hp2_q;
        judg_d  = judg_q;
        lock1_d = '0;
        lock2_d = '0;
        wait_d  = '0;
        next_d  = 1'b0;
        case (state_q)
            IDLE: state_d = START ? PLAY : IDLE;
            PLAY: begin
                hp1_d = hp1_n;
                hp2_d = hp2_n;
                if (hp1_n == 2'd0 || hp2_n == 2'd0) begin
                    state_d = OVER;
                    judg_d  = {hp1_n == 2'd0, hp2_n == 2'd0};
                end else if (ok1_v || ok2_v) begin
                    state_d = WAIT;
                end else begin
                    lock1_d = miss1_v ? LW'(LOCK_CYC) : (lock1_q != '0 ? lock1_q - LW'(1) : lock1_q);
                    lock2_d = miss2_v ? LW'(LOCK_CYC) : (lock2_q != '0 ? lock2_q - LW'(1) : lock2_q);
                end
            end
            WAIT: begin
                if (wait_q == NW'(NEXT_CYC - 1)) begin
                    state_d = PLAY;
                    next_d  = 1'b1;
                end else begin
                    wait_d = wait_q + NW'(1);
                end
            end
            OVER: begin
                if (START) begin
                    state_d = PLAY;
                    hp1_d   = 2'(HP_INIT);
                    hp2_d   = 2'(HP_INIT);
                    judg_d  = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset overriding every input
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            hp1_q   <= 2'(HP_INIT);
            hp2_q   <= 2'(HP_INIT);
            judg_q  <= 2'b00;
            lock1_q <= '0;
            lock2_q <= '0;
            wait_q  <= '0;
            next_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hp1_q   <= hp1_d;
            hp2_q   <= hp2_d;
            judg_q  <= judg_d;
            lock1_q <= lock1_d;
            lock2_q <= lock2_d;
            wait_q  <= wait_d;
            next_q  <= next_d;
        end
    end

    assign STATE  = state_q;
    assign JUDG   = judg_q;
    assign HP1    = hp1_q;
    assign HP2    = hp2_q;
    assign WRONG1 = lock1_q != '0;
    assign WRONG2 = lock2_q != '0;
    assign NEXT   = next_q;
endmodule
